mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-to-1 mux datapath among eight requesters. It drives the mux select (`sel`) and a one-hot grant vector. Each grant lasts until the requester drops its request or completes `MAX_HOLD` accepted transfers. It sits directly in front of `eighttoonemux`: `sel` connects to the mux `s` input, and requester *i* drives mux data bit `a[i]`.

---
 rtl/mux_rr_arbiter.sv | 61 ++++++
 tb/tb_mux_rr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the select of an 8-to-1 mux shared by eight requesters
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   req   : per-requester request lines, held while the mux is wanted
//   ready : downstream samples the mux output this cycle
//   sel   : mux select, index of the granted requester, held when idle
//   gnt   : one-hot grant, zero when idle
//   busy  : a grant is held
//   xfer  : one accepted transfer this cycle
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       ready,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       xfer
);
   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;
   logic       state;
   logic [2:0] ptr;
   logic [3:0] cnt;
   logic [2:0] base;
   logic [2:0] off;
   logic [2:0] pick;
   logic [7:0] rot;
   logic       rel;
   assign busy = state == GRANT;
   assign xfer = busy & ready & req[sel];
   assign rel  = busy & (~req[sel] | (xfer & (cnt == 4'(MAX_HOLD - 1))));
   // On release the search starts just past the releasing requester, so it is considered last.
   always_comb begin
      base = busy ? sel + 3'd1 : ptr;
      rot  = 8'({req, req} >> base);
      off  = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (rot[i]) off = 3'(i);
      pick = base + off;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 3'd0;
         cnt   <= 4'd0;
         sel   <= 3'd0;
         gnt   <= 8'd0;
      end else if (busy ? rel : |req) begin
         if (busy) ptr <= sel + 3'd1;
         state <= |req ? GRANT : IDLE;
         sel   <= |req ? pick : sel;
         gnt   <= |req ? 8'd1 << pick : 8'd0;
         cnt   <= 4'd0;
      end else if (xfer) begin
         cnt <= cnt + 4'd1;
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: table, directed and randomized checks of mux_rr_arbiter against a reference model
module tb_mux_rr_arbiter;
   localparam int MH = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       ready = 1'b0;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       busy;
   logic       xfer;
   int n_tests = 0;
   int n_fail  = 0;
   int mg   = -1;
   int mptr = 0;
   int mcnt = 0;
   int msel = 0;

   mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req), .ready(ready),
      .sel(sel), .gnt(gnt), .busy(busy), .xfer(xfer)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [7:0] q;
      logic       rd;
      logic [7:0] g;
      logic [2:0] s;
      logic       b;
      logic       x;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic expect_out(input string name, input logic [7:0] g, input logic [2:0] s,
                             input logic b, input logic x);
      chk({name, ".gnt"}, 32'(gnt), 32'(g));
      chk({name, ".sel"}, 32'(sel), 32'(s));
      chk({name, ".busy"}, 32'(busy), 32'(b));
      chk({name, ".xfer"}, 32'(xfer), 32'(x));
   endtask

   function automatic int arb(input logic [7:0] v, input int p);
      for (int k = 0; k < 8; k++)
         if (v[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   function automatic logic model_xfer();
      return mg >= 0 && ready && req[msel];
   endfunction

   task automatic check_model(input string name);
      expect_out(name, mg < 0 ? 8'h00 : 8'(1 << mg), 3'(msel), mg >= 0, model_xfer());
   endtask

   task automatic apply(input logic r, input logic [7:0] q, input logic rd);
      rst = r;
      req = q;
      ready = rd;
      #1;
   endtask

   task automatic tick();
      logic x;
      @(posedge clk);
      x = model_xfer();
      if (rst) begin
         mg = -1; mptr = 0; mcnt = 0; msel = 0;
      end else if (mg < 0) begin
         if (req != 0) begin
            mg = arb(req, mptr); msel = mg; mcnt = 0;
         end
      end else if (!req[mg] || (x && mcnt == MH - 1)) begin
         mptr = (mg + 1) % 8;
         mcnt = 0;
         if (req != 0) begin
            mg = arb(req, mptr); msel = mg;
         end else mg = -1;
      end else if (x) mcnt++;
      @(negedge clk);
   endtask

   task automatic reset_dut();
      apply(1'b1, 8'h00, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      tick();
      tbl[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].r, tbl[i].q, tbl[i].rd);
         expect_out($sformatf("tbl%0d", i), tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].x);
         check_model($sformatf("tbl%0d.model", i));
         tick();
      end

      reset_dut();
      apply(1'b0, 8'h02, 1'b1);
      tick();
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, 8'h02, 1'b1);
         expect_out("single", 8'h02, 3'd1, 1'b1, 1'b1);
         tick();
      end

      reset_dut();
      apply(1'b0, 8'h18, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, 8'h18, 1'b0);
         expect_out("stall", 8'h08, 3'd3, 1'b1, 1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 8'h18, 1'b1);
         expect_out("stall_go", 8'h08, 3'd3, 1'b1, 1'b1);
         tick();
      end
      apply(1'b0, 8'h18, 1'b1);
      expect_out("stall_next", 8'h10, 3'd4, 1'b1, 1'b1);
      tick();

      reset_dut();
      apply(1'b0, 8'h24, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 8'h24, 1'b1);
         expect_out("wd", 8'h04, 3'd2, 1'b1, 1'b1);
         tick();
      end
      apply(1'b0, 8'h20, 1'b1);
      expect_out("wd_drop", 8'h04, 3'd2, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 8'h20, 1'b1);
         expect_out("wd_new", 8'h20, 3'd5, 1'b1, 1'b1);
         tick();
      end

      reset_dut();
      apply(1'b0, 8'h24, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 8'h24, 1'b1);
         tick();
      end
      apply(1'b0, 8'h00, 1'b1);
      expect_out("wd0_drop", 8'h04, 3'd2, 1'b1, 1'b0);
      tick();
      apply(1'b0, 8'h00, 1'b1);
      expect_out("wd0_idle", 8'h00, 3'd2, 1'b0, 1'b0);
      tick();

      reset_dut();
      apply(1'b0, 8'h40, 1'b1);
      tick();
      apply(1'b0, 8'h40, 1'b1);
      expect_out("mrst_g6", 8'h40, 3'd6, 1'b1, 1'b1);
      tick();
      apply(1'b1, 8'h40, 1'b1);
      tick();
      apply(1'b0, 8'h41, 1'b1);
      expect_out("mrst_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      apply(1'b0, 8'h41, 1'b1);
      expect_out("mrst_g0", 8'h01, 3'd0, 1'b1, 1'b1);
      tick();

      reset_dut();
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] q;
         q = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 9) == 0) q = 8'h00;
         apply($urandom_range(0, 149) == 0, q, $urandom_range(0, 3) != 0);
         check_model("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
